// File: rtl/imm_ext_pipe_if.sv
// ============================================================================
// Module : imm_ext_pipe_if
// Brief  : Request/result handshake bundle for imm_ext_pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imm_ext_pipe_if #(
   parameter int IW = 16,
   parameter int OW = 32
) ();
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] imm;
   logic [2:0]    eop;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_ovf;
   logic          out_err;

   modport master (
      output in_valid, imm, eop, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_err
   );

   modport slave (
      input  in_valid, imm, eop, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_err
   );
endinterface

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// Module : imm_ext_pipe
// Brief  : Immediate extender with a 2-entry result FIFO; optional request
//          counter enabled by macro IMM_EXT_PIPE_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe #(
   parameter int IW = 16,
   parameter int OW = 32,
   parameter int SH = 2
) (
   input  logic          clk,
   input  logic          reset,
   imm_ext_pipe_if.slave bus
`ifdef IMM_EXT_PIPE_STATS_EN
   ,
   output logic [15:0]   op_count
`endif
);

   localparam logic [2:0] c_EOP_SEXT    = 3'd0;
   localparam logic [2:0] c_EOP_ZEXT    = 3'd1;
   localparam logic [2:0] c_EOP_TOP     = 3'd2;
   localparam logic [2:0] c_EOP_SEXT_SH = 3'd3;
   localparam logic [2:0] c_EOP_ZEXT_SH = 3'd4;

   logic [OW-1:0] w_sext;
   logic [OW-1:0] w_zext;
   logic          w_ovf_s;
   logic          w_ovf_z;
   logic [OW-1:0] w_res_data;
   logic          w_res_ovf;
   logic          w_res_err;

   assign w_sext = OW'($signed(bus.imm));
   assign w_zext = OW'(bus.imm);

   // Shifted-out bits are the top SH bits of the extended value.
   always_comb begin
      w_ovf_s = 1'b0;
      w_ovf_z = 1'b0;
      for (int i = OW - SH; i < OW; i++) begin
         if (w_sext[i] != w_sext[OW-1-SH]) w_ovf_s = 1'b1;
         if (w_zext[i]) w_ovf_z = 1'b1;
      end
   end

   always_comb begin
      w_res_data = '0;
      w_res_ovf  = 1'b0;
      w_res_err  = 1'b0;
      case (bus.eop)
         c_EOP_SEXT:    w_res_data = w_sext;
         c_EOP_ZEXT:    w_res_data = w_zext;
         c_EOP_TOP:     w_res_data = w_zext << (OW - IW);
         c_EOP_SEXT_SH: begin
            w_res_data = w_sext << SH;
            w_res_ovf  = w_ovf_s;
         end
         c_EOP_ZEXT_SH: begin
            w_res_data = w_zext << SH;
            w_res_ovf  = w_ovf_z;
         end
         default:       w_res_err = 1'b1;
      endcase
   end

   logic [OW-1:0] r_data [0:1];
   logic [1:0]    r_ovf;
   logic [1:0]    r_err;
   logic          r_wr;
   logic          r_rd;
   logic [1:0]    r_count;
   logic          r_rdy_en;
   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;

   // r_rdy_en keeps in_ready low until the first edge after reset release.
   assign w_in_ready  = r_rdy_en & (r_count != 2'd2);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_ovf     <= '0;
         r_err     <= '0;
         r_wr      <= 1'b0;
         r_rd      <= 1'b0;
         r_count   <= 2'd0;
         r_rdy_en  <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_push) begin
            r_data[r_wr] <= w_res_data;
            r_ovf[r_wr]  <= w_res_ovf;
            r_err[r_wr]  <= w_res_err;
            r_wr         <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_data[r_rd] : '0;
   assign bus.out_ovf   = w_out_valid & r_ovf[r_rd];
   assign bus.out_err   = w_out_valid & r_err[r_rd];

`ifdef IMM_EXT_PIPE_STATS_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_op_count <= 16'd0;
      else if (w_push) r_op_count <= r_op_count + 16'd1;
   end

   assign op_count = r_op_count;
`endif

endmodule

`default_nettype wire
